// File: rtl/vote_collector_if.sv
// Handshake bundle between the serial vote source, the collector and the majority stage.
// The collector sits on the slave side; the feeder/consumer pair drives the master side.
interface vote_collector_if #(
    parameter int NUM_VOTES = 5
);
    logic                 in_valid;
    logic                 in_ready;
    logic                 in_bit;
    logic                 in_sof;
    logic                 out_valid;
    logic                 out_ready;
    logic [NUM_VOTES-1:0] out_votes;
    logic                 frame_err;

    modport master (
        output in_valid, in_bit, in_sof, out_ready,
        input  in_ready, out_valid, out_votes, frame_err
    );

    modport slave (
        input  in_valid, in_bit, in_sof, out_ready,
        output in_ready, out_valid, out_votes, frame_err
    );
endinterface

// File: rtl/vote_collector.sv
// Serial-to-parallel vote collector: packs NUM_VOTES single-bit votes (first vote in bit 0)
// into one word for the majority stage, realigning on start-of-frame.
module vote_collector #(
    parameter int NUM_VOTES   = 5,
    parameter bit REQUIRE_SOF = 1'b0
) (
    input  logic          clk,
    input  logic          rst,
    vote_collector_if.slave bus
);
    localparam int            CW        = (NUM_VOTES > 1) ? $clog2(NUM_VOTES) : 1;
    localparam logic [CW-1:0] CNT_FIRST = (NUM_VOTES > 1) ? CW'(1) : CW'(0);
    localparam logic [CW-1:0] CNT_LAST  = CW'(NUM_VOTES - 1);

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        COLLECT = 2'd1,
        FULL    = 2'd2
    } state_t;

    // A single-vote frame is complete as soon as its first bit lands.
    localparam state_t FIRST_DONE = (NUM_VOTES == 1) ? FULL : COLLECT;

    state_t               r_state;
    state_t               w_next_state;
    logic [CW-1:0]        r_cnt;
    logic [NUM_VOTES-1:0] r_votes;
    logic                 r_out_valid;
    logic                 r_frame_err;

    logic w_in_ready;
    logic w_accept;
    logic w_handoff;
    logic w_sof_ok;
    logic w_restart;
    logic w_append;
    logic w_realign;

    assign w_accept  = bus.in_valid & w_in_ready;
    assign w_handoff = r_out_valid & bus.out_ready;
    assign w_sof_ok  = bus.in_sof | ~REQUIRE_SOF;
    assign w_realign = w_accept & (r_state == COLLECT) & bus.in_sof;
    assign w_append  = w_accept & (r_state == COLLECT) & ~bus.in_sof;
    assign w_restart = w_accept & (bus.in_sof | ((r_state != COLLECT) & ~REQUIRE_SOF));

    // NOTE: sequential state is written with <= so every flop samples pre-edge values.
    always_ff @(posedge clk) begin
        if (rst) r_state <= IDLE;
        else     r_state <= w_next_state;
    end

    // NOTE: default assignment first so no path through the case infers a latch.
    always_comb begin
        w_next_state = r_state;
        case (r_state)
            IDLE: begin
                if (w_accept && w_sof_ok) w_next_state = FIRST_DONE;
            end
            COLLECT: begin
                if (w_accept) begin
                    if (bus.in_sof)              w_next_state = FIRST_DONE;
                    else if (r_cnt == CNT_LAST)  w_next_state = FULL;
                end
            end
            FULL: begin
                if (w_handoff) w_next_state = (w_accept && w_sof_ok) ? FIRST_DONE : IDLE;
            end
            default: w_next_state = IDLE;
        endcase
    end

    // Only FULL lets backpressure from the majority stage reach the serial side.
    always_comb begin
        w_in_ready = 1'b1;
        if (rst)                  w_in_ready = 1'b0;
        else if (r_state == FULL) w_in_ready = bus.out_ready;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_cnt       <= '0;
            r_votes     <= '0;
            r_out_valid <= 1'b0;
            r_frame_err <= 1'b0;
        end else begin
            r_out_valid <= (w_next_state == FULL);
            r_frame_err <= w_realign;
            if (w_restart) begin
                r_votes[0] <= bus.in_bit;
                r_cnt      <= CNT_FIRST;
            end else if (w_append) begin
                for (int i = 0; i < NUM_VOTES; i++) begin
                    if (r_cnt == CW'(i)) r_votes[i] <= bus.in_bit;
                end
                r_cnt <= (r_cnt == CNT_LAST) ? '0 : r_cnt + 1'b1;
            end
        end
    end

    assign bus.in_ready  = w_in_ready;
    assign bus.out_valid = r_out_valid;
    assign bus.out_votes = r_votes;
    assign bus.frame_err = r_frame_err;
endmodule

// File: tb/tb_vote_collector.sv
// Bench for vote_collector: three instances (5 votes, 5 votes with SOF required, 1 vote)
// compared every cycle against a queue-based frame model, plus directed frame checks.
module tb_vote_collector;
    logic clk = 1'b0;
    logic rst;
    logic [2:0] t_valid, t_bit, t_sof, t_oready;

    always #5 clk = ~clk;

    vote_collector_if #(.NUM_VOTES(5)) if0 ();
    vote_collector_if #(.NUM_VOTES(5)) if1 ();
    vote_collector_if #(.NUM_VOTES(1)) if2 ();

    assign if0.in_valid = t_valid[0];
    assign if0.in_bit   = t_bit[0];
    assign if0.in_sof   = t_sof[0];
    assign if0.out_ready = t_oready[0];
    assign if1.in_valid = t_valid[1];
    assign if1.in_bit   = t_bit[1];
    assign if1.in_sof   = t_sof[1];
    assign if1.out_ready = t_oready[1];
    assign if2.in_valid = t_valid[2];
    assign if2.in_bit   = t_bit[2];
    assign if2.in_sof   = t_sof[2];
    assign if2.out_ready = t_oready[2];

    vote_collector #(.NUM_VOTES(5), .REQUIRE_SOF(1'b0)) u_dut0 (.clk(clk), .rst(rst), .bus(if0.slave));
    vote_collector #(.NUM_VOTES(5), .REQUIRE_SOF(1'b1)) u_dut1 (.clk(clk), .rst(rst), .bus(if1.slave));
    vote_collector #(.NUM_VOTES(1), .REQUIRE_SOF(1'b0)) u_dut2 (.clk(clk), .rst(rst), .bus(if2.slave));

    // Reference model: a frame is the list of accepted bits; it is handed over once full.
    int          nv  [3] = '{5, 5, 1};
    bit          req [3] = '{1'b0, 1'b1, 1'b0};
    bit          m_part [3][$];
    bit          m_have [3];
    bit          m_err  [3];
    logic [15:0] m_frame [3];

    int n_checks = 0;
    int n_fail   = 0;

    function automatic logic [15:0] obs_votes(int d);
        case (d)
            0:       return 16'(if0.out_votes);
            1:       return 16'(if1.out_votes);
            default: return 16'(if2.out_votes);
        endcase
    endfunction

    function automatic logic obs_ready(int d);
        case (d)
            0:       return if0.in_ready;
            1:       return if1.in_ready;
            default: return if2.in_ready;
        endcase
    endfunction

    function automatic logic obs_valid(int d);
        case (d)
            0:       return if0.out_valid;
            1:       return if1.out_valid;
            default: return if2.out_valid;
        endcase
    endfunction

    function automatic logic obs_err(int d);
        case (d)
            0:       return if0.frame_err;
            1:       return if1.frame_err;
            default: return if2.frame_err;
        endcase
    endfunction

    task automatic check(string tag, logic [15:0] obs, logic [15:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    function automatic bit model_ready(int d);
        if (rst) return 1'b0;
        return m_have[d] ? t_oready[d] : 1'b1;
    endfunction

    task automatic model_update(int d, bit rdy);
        bit acc;
        if (rst) begin
            m_part[d].delete();
            m_have[d]  = 1'b0;
            m_err[d]   = 1'b0;
            m_frame[d] = '0;
            return;
        end
        acc      = t_valid[d] & rdy;
        m_err[d] = 1'b0;
        if (m_have[d] && t_oready[d]) m_have[d] = 1'b0;
        if (acc) begin
            if (t_sof[d] && m_part[d].size() > 0) begin
                m_err[d] = 1'b1;
                m_part[d].delete();
            end
            if (!(m_part[d].size() == 0 && req[d] && !t_sof[d])) begin
                m_part[d].push_back(t_bit[d]);
                if (m_part[d].size() == nv[d]) begin
                    m_frame[d] = '0;
                    for (int i = 0; i < nv[d]; i++) m_frame[d][i] = m_part[d][i];
                    m_have[d] = 1'b1;
                    m_part[d].delete();
                end
            end
        end
    endtask

    // One clock: inputs were set at the preceding falling edge.
    task automatic cycle();
        bit rdy [3];
        bit was_rst;
        #1;
        for (int d = 0; d < 3; d++) begin
            rdy[d] = model_ready(d);
            check($sformatf("d%0d_in_ready", d), 16'(obs_ready(d)), 16'(rdy[d]));
        end
        was_rst = rst;
        for (int d = 0; d < 3; d++) model_update(d, rdy[d]);
        @(posedge clk);
        #1;
        for (int d = 0; d < 3; d++) begin
            check($sformatf("d%0d_out_valid", d), 16'(obs_valid(d)), 16'(m_have[d]));
            check($sformatf("d%0d_frame_err", d), 16'(obs_err(d)), 16'(m_err[d]));
            if (m_have[d]) check($sformatf("d%0d_out_votes", d), obs_votes(d), m_frame[d]);
            if (was_rst)   check($sformatf("d%0d_reset_votes", d), obs_votes(d), 16'h0);
        end
        @(negedge clk);
    endtask

    task automatic drv(int d, bit v, bit b, bit s, bit r);
        t_valid[d]  = v;
        t_bit[d]    = b;
        t_sof[d]    = s;
        t_oready[d] = r;
    endtask

    initial begin
        logic [4:0] w;
        t_valid  = '0;
        t_bit    = '0;
        t_sof    = '0;
        t_oready = '0;
        rst      = 1'b1;
        for (int d = 0; d < 3; d++) begin
            m_have[d]  = 1'b0;
            m_err[d]   = 1'b0;
            m_frame[d] = '0;
        end
        @(negedge clk);
        cycle();
        cycle();
        rst = 1'b0;

        // Two back-to-back frames 1,0,1,1,0 with no backpressure.
        w = 5'b01101;
        for (int f = 0; f < 2; f++) begin
            for (int i = 0; i < 5; i++) begin
                drv(0, 1'b1, w[i], i == 0, 1'b1);
                cycle();
            end
            check("tp1_valid", 16'(if0.out_valid), 16'h1);
            check("tp1_votes", 16'(if0.out_votes), 16'h000d);
        end
        drv(0, 1'b0, 1'b0, 1'b0, 1'b1);
        cycle();
        check("tp1_drain", 16'(if0.out_valid), 16'h0);

        // Backpressure: frame held stable, in_ready low until the consumer takes it.
        w = 5'b10011;
        for (int i = 0; i < 5; i++) begin
            drv(0, 1'b1, w[i], i == 0, 1'b0);
            cycle();
        end
        for (int k = 0; k < 4; k++) begin
            drv(0, 1'b1, 1'b1, 1'b1, 1'b0);
            #1;
            check("tp2_in_ready_low", 16'(if0.in_ready), 16'h0);
            cycle();
            check("tp2_votes_stable", 16'(if0.out_votes), 16'h0013);
        end
        drv(0, 1'b1, 1'b1, 1'b1, 1'b1);
        #1;
        check("tp2_in_ready_pass", 16'(if0.in_ready), 16'h1);
        cycle();
        check("tp2_handoff", 16'(if0.out_valid), 16'h0);
        for (int i = 0; i < 4; i++) begin
            drv(0, 1'b1, 1'b0, 1'b0, 1'b1);
            cycle();
        end
        check("tp2_bit0_frame", 16'(if0.out_votes), 16'h0001);

        // Realign: three bits, then a new start-of-frame.
        for (int i = 0; i < 3; i++) begin
            drv(0, 1'b1, 1'b1, i == 0, 1'b1);
            cycle();
        end
        drv(0, 1'b1, 1'b0, 1'b1, 1'b1);
        cycle();
        check("tp3_err_pulse", 16'(if0.frame_err), 16'h1);
        for (int i = 0; i < 4; i++) begin
            drv(0, 1'b1, 1'b1, 1'b0, 1'b1);
            cycle();
            if (i == 0) check("tp3_err_single", 16'(if0.frame_err), 16'h0);
        end
        check("tp3_valid", 16'(if0.out_valid), 16'h1);
        check("tp3_votes", 16'(if0.out_votes), 16'h001e);
        drv(0, 1'b0, 1'b0, 1'b0, 1'b1);
        cycle();

        // Start-of-frame required: leading non-SOF bits are dropped.
        for (int i = 0; i < 2; i++) begin
            drv(1, 1'b1, 1'b1, 1'b0, 1'b1);
            cycle();
        end
        check("tp4_dropped", 16'(if1.out_valid), 16'h0);
        w = 5'b10110;
        for (int i = 0; i < 5; i++) begin
            drv(1, 1'b1, w[i], i == 0, 1'b1);
            cycle();
        end
        check("tp4_valid", 16'(if1.out_valid), 16'h1);
        check("tp4_votes", 16'(if1.out_votes), 16'h0016);
        drv(1, 1'b0, 1'b0, 1'b0, 1'b1);
        cycle();

        // Reset mid-frame.
        for (int i = 0; i < 2; i++) begin
            drv(0, 1'b1, 1'b1, i == 0, 1'b1);
            cycle();
        end
        rst = 1'b1;
        drv(0, 1'b1, 1'b1, 1'b1, 1'b1);
        #1;
        check("tp5_in_ready_rst", 16'(if0.in_ready), 16'h0);
        cycle();
        check("tp5_valid", 16'(if0.out_valid), 16'h0);
        check("tp5_votes", 16'(if0.out_votes), 16'h0);
        check("tp5_no_err", 16'(if0.frame_err), 16'h0);
        rst = 1'b0;
        w = 5'b10100;
        for (int i = 0; i < 5; i++) begin
            drv(0, 1'b1, w[i], i == 0, 1'b1);
            cycle();
        end
        check("tp5_after_rst", 16'(if0.out_votes), 16'h0014);
        drv(0, 1'b0, 1'b0, 1'b0, 1'b1);
        cycle();

        // Single-vote frames stream one per cycle.
        w = 5'b00101;
        for (int i = 0; i < 3; i++) begin
            drv(2, 1'b1, w[i], 1'b0, 1'b1);
            cycle();
            check("tp6_valid", 16'(if2.out_valid), 16'h1);
            check("tp6_votes", 16'(if2.out_votes), 16'(w[i]));
        end
        drv(2, 1'b0, 1'b0, 1'b0, 1'b1);
        cycle();

        // Random traffic on all three instances, with occasional resets.
        for (int n = 0; n < 3000; n++) begin
            for (int d = 0; d < 3; d++) begin
                drv(d, $urandom_range(0, 3) != 0, 1'($urandom), $urandom_range(0, 7) == 0,
                    $urandom_range(0, 3) != 0);
            end
            rst = ($urandom_range(0, 299) == 0);
            cycle();
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule
